// File: rtl/serial_add_if.sv
// Handshake and result bundle between a requester and the bit-serial adder sequencer.
interface serial_add_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, op_a, op_b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add_sequencer.sv
// Drives one shared 1-bit full-adder cell for WIDTH clocks to form a WIDTH-bit sum,
// LSB first, with the running carry held in a register between bits.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   serial_add_if.slave  bus,
   output logic         fa_a,
   output logic         fa_b,
   output logic         fa_c,
   input  logic         fa_s,
   input  logic         fa_co
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             cout_r;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh   <= bus.op_a;
                  b_sh   <= bus.op_b;
                  carry  <= bus.cin;
                  cnt    <= '0;
                  sum_r  <= '0;
                  cout_r <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
               sum_r <= {fa_s, sum_r[WIDTH-1:1]};
               carry <= fa_co;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  cout_r <= fa_co;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The cell sees only zeros outside RUN, so the leftover carry never leaks out.
   assign fa_a = (state == RUN) & a_sh[0];
   assign fa_b = (state == RUN) & b_sh[0];
   assign fa_c = (state == RUN) & carry;

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer with a behavioural full adder
// and a result scoreboard checked whenever done pulses.
module tb_serial_add_sequencer;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   logic fa_a, fa_b, fa_c, fa_s, fa_co;

   serial_add_if #(.WIDTH(W)) bus ();

   serial_add_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .fa_a  (fa_a),
      .fa_b  (fa_b),
      .fa_c  (fa_c),
      .fa_s  (fa_s),
      .fa_co (fa_co)
   );

   assign fa_s  = fa_a ^ fa_b ^ fa_c;
   assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W:0] exp_q[$];
   logic prev_done = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compares every done against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got sum=0x%0h cout=%0d, expected no done", bus.sum, bus.cout);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               check("result", {bus.cout, bus.sum}, e);
            end
            check("done_not_back_to_back", prev_done, 0);
         end
         if (!bus.busy || bus.done)
            check("fa_idle_zero", {fa_a, fa_b, fa_c}, 0);
      end
      prev_done = bus.done;
   end

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (bus.busy) check("idle_timeout", 1, 0);
   endtask

   // Issue one add, push its expected result, then verify latency and busy span.
   task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int lat;
      int bc;
      wait_idle();
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = c;
      @(posedge clk);
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
      #1;
      bus.start = 1'b0;
      bus.op_a  = W'($urandom);
      bus.op_b  = W'($urandom);
      bus.cin   = 1'($urandom);
      lat = 0;
      bc  = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.busy) bc++;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, W + 1);
      check("busy_cycles", bc, W + 1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.cin   = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {bus.busy, bus.done, bus.cout, bus.sum}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_add(8'h5A, 8'h3C, 1'b0);
      check("t1_sum_hold", {bus.cout, bus.sum}, 9'h096);
      do_add(8'hFF, 8'h01, 1'b0);
      do_add(8'hFF, 8'hFF, 1'b1);
      do_add(8'h00, 8'h00, 1'b0);

      // start held high through RUN/DONE must not queue a second add.
      wait_idle();
      bus.start = 1'b1;
      bus.op_a  = 8'h12;
      bus.op_b  = 8'h34;
      bus.cin   = 1'b0;
      @(posedge clk);
      exp_q.push_back(9'h046);
      #1;
      bus.op_a = 8'hAA;
      bus.op_b = 8'h55;
      @(negedge clk);
      wait_idle();
      @(posedge clk);
      exp_q.push_back(9'h0FF);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      wait_idle();
      check("t4_queue_drained", exp_q.size(), 0);

      // Reset in the 4th RUN cycle aborts with no done.
      bus.start = 1'b1;
      bus.op_a  = 8'h80;
      bus.op_b  = 8'h80;
      bus.cin   = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {bus.busy, bus.done, bus.cout, bus.sum}, 0);
      check("abort_fa", {fa_a, fa_b, fa_c}, 0);
      repeat (12) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_abort_idle", {bus.busy, bus.done}, 0);
      do_add(8'h01, 8'h02, 1'b0);
      check("post_abort_sum", {bus.cout, bus.sum}, 9'h003);

      for (int n = 0; n < 1000; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         do_add(W'($urandom), W'($urandom), 1'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
